// File: rtl/alu_mc_if.sv
// Request/response bundle for alu_mc: operands and op select in, registered result,
// flags and HI/LO out, with a valid/ready handshake.
interface alu_mc_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       ALU_Ctrl;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             dbz;
    logic             out_valid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, a, b, ALU_Ctrl,
        input  in_ready, result, zero, overflow, dbz, out_valid, hi, lo
    );

    modport slave (
        input  in_valid, a, b, ALU_Ctrl,
        output in_ready, result, zero, overflow, dbz, out_valid, hi, lo
    );
endinterface

// File: rtl/alu_mc.sv
// Registered EX-stage ALU: single-cycle logic/arith/shift/compare ops plus iterative
// unsigned multiply (shift-add) and divide (restoring) into HI/LO over WIDTH clocks.
module alu_mc #(
    parameter int unsigned WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    alu_mc_if.slave   bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

    localparam logic [3:0] OpAnd   = 4'b0000;
    localparam logic [3:0] OpOr    = 4'b0001;
    localparam logic [3:0] OpXor   = 4'b0011;
    localparam logic [3:0] OpNor   = 4'b0100;
    localparam logic [3:0] OpSll   = 4'b0101;
    localparam logic [3:0] OpSub   = 4'b0110;
    localparam logic [3:0] OpSlt   = 4'b0111;
    localparam logic [3:0] OpSltu  = 4'b1000;
    localparam logic [3:0] OpSrl   = 4'b1001;
    localparam logic [3:0] OpSra   = 4'b1010;
    localparam logic [3:0] OpMultu = 4'b1011;
    localparam logic [3:0] OpDivu  = 4'b1100;
    localparam logic [3:0] OpMfhi  = 4'b1101;
    localparam logic [3:0] OpMflo  = 4'b1110;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] wa_q, wa_d;     // product high / partial remainder
    logic [WIDTH-1:0] wb_q, wb_d;     // multiplier bits / dividend-then-quotient
    logic [WIDTH-1:0] opnd_q, opnd_d; // multiplicand / divisor
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             alu_ovf;

    assign shamt = bus.a[SHW-1:0];
    assign sum   = bus.a + bus.b;
    assign diff  = bus.a - bus.b;

    always_comb begin
        alu_res = sum;
        alu_ovf = 1'b0;
        case (bus.ALU_Ctrl)
            OpAnd:  alu_res = bus.a & bus.b;
            OpOr:   alu_res = bus.a | bus.b;
            OpXor:  alu_res = bus.a ^ bus.b;
            OpNor:  alu_res = ~(bus.a | bus.b);
            OpSll:  alu_res = bus.b << shamt;
            OpSrl:  alu_res = bus.b >> shamt;
            OpSra:  alu_res = WIDTH'($signed(bus.b) >>> shamt);
            OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            OpSltu: alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            OpMfhi: alu_res = hi_q;
            OpMflo: alu_res = lo_q;
            OpSub: begin
                alu_res = diff;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            default: begin
                alu_res = sum;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
        endcase
    end

    // One shift-add step: add multiplicand when the current multiplier LSB is set.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
    assign mul_sum   = {1'b0, wa_q} + (wb_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_hi_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], wb_q[WIDTH-1:1]};

    // One restoring step; a zero divisor naturally yields all-ones quotient and rem = a.
    logic [WIDTH:0]   div_shift, div_trial;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem_nx, div_quo_nx;
    assign div_shift  = {wa_q, wb_q[WIDTH-1]};
    assign div_trial  = div_shift - {1'b0, opnd_q};
    assign div_ok     = div_shift >= {1'b0, opnd_q};
    assign div_rem_nx = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo_nx = {wb_q[WIDTH-2:0], div_ok};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wa_d     = wa_q;
        wb_d     = wb_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        valid_d  = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    case (bus.ALU_Ctrl)
                        OpMultu: begin
                            wa_d    = '0;
                            wb_d    = bus.b;
                            opnd_d  = bus.a;
                            cnt_d   = '0;
                            state_d = StMul;
                        end
                        OpDivu: begin
                            wa_d    = '0;
                            wb_d    = bus.a;
                            opnd_d  = bus.b;
                            cnt_d   = '0;
                            state_d = StDiv;
                        end
                        default: begin
                            result_d = alu_res;
                            zero_d   = (alu_res == '0);
                            ovf_d    = alu_ovf;
                            dbz_d    = 1'b0;
                            valid_d  = 1'b1;
                        end
                    endcase
                end
            end
            StMul: begin
                wa_d  = mul_hi_nx;
                wb_d  = mul_lo_nx;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == CntLast) begin
                    hi_d     = mul_hi_nx;
                    lo_d     = mul_lo_nx;
                    result_d = mul_lo_nx;
                    zero_d   = (mul_lo_nx == '0);
                    ovf_d    = 1'b0;
                    dbz_d    = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = StIdle;
                end
            end
            StDiv: begin
                wa_d  = div_rem_nx;
                wb_d  = div_quo_nx;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == CntLast) begin
                    hi_d     = div_rem_nx;
                    lo_d     = div_quo_nx;
                    result_d = div_quo_nx;
                    zero_d   = (div_quo_nx == '0);
                    ovf_d    = 1'b0;
                    dbz_d    = (opnd_q == '0);
                    valid_d  = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            wa_q     <= '0;
            wb_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            valid_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wa_q     <= wa_d;
            wb_q     <= wb_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
            valid_q  <= valid_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.dbz       = dbz_q;
    assign bus.out_valid = valid_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised, registered successor to the single-cycle datapath ALU. It adds signed overflow, unsigned compare, logic and shift ops, and iterative unsigned multiply/divide with HI/LO registers. It sits in the EX stage and uses a valid/ready handshake, so the pipeline controller can stall on multi-cycle ops. Single-cycle ops complete in one clock. MULTU/DIVU take WIDTH+1 clocks.

Parameters:
WIDTH, 32, operand/result width in bits (>=8, power of two)
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  high when the block can accept an op (IDLE)
a  input  WIDTH  operand A (shift amount source for shifts: a[SHW-1:0])
b  input  WIDTH  operand B (value shifted for shifts)
ALU_Ctrl  input  4  operation select
result  output  WIDTH  registered result
zero  output  1  registered (result==0)
overflow  output  1  registered signed overflow (add/sub only, else 0)
dbz  output  1  divide-by-zero flag, valid with out_valid
out_valid  output  1  one-cycle pulse: result/flags/hi/lo updated
hi  output  WIDTH  HI register (product high / remainder)
lo  output  WIDTH  LO register (product low / quotient)

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset: result=0, zero=0, overflow=0, dbz=0, out_valid=0, hi=0, lo=0, state=IDLE, in_ready=1 in the first cycle after rst deasserts.
- Reset mid-operation aborts the op: no out_valid, hi/lo cleared.
- An op is accepted on a rising edge where in_valid&&in_ready. in_valid while in_ready=0 is ignored; it is not queued.
- Encodings:
  - 0000 and, 0001 or, 0010 add, 0011 xor, 0100 nor, 0110 sub
  - 0101 sll (b<<a[SHW-1:0]), 1001 srl, 1010 sra
  - 0111 slt signed, 1000 sltu
  - 1011 multu, 1100 divu, 1101 mfhi, 1110 mflo
  - 1111 and all undefined: add
- Single-cycle ops (everything except 1011/1100):
  - result, zero and overflow are registered on the accepting edge.
  - out_valid=1 for exactly the following cycle. in_ready stays 1, so back-to-back ops are accepted every cycle.
  - hi/lo unchanged. mfhi/mflo return the current hi/lo.
- overflow:
  - add: sign(a)==sign(b) && sign(sum)!=sign(a)
  - sub: sign(a)!=sign(b) && sign(diff)!=sign(a)
  - 0 for every other op. Wrap-around result is still written.
- slt/sltu: result = {WIDTH-1 zeros, cmp}.
- States: IDLE, MUL, DIV.
  - Accepting multu/divu latches a, b; moves IDLE->MUL/DIV; in_ready drops to 0 the next cycle.
  - Counter 0..WIDTH-1: one shift-add (MUL) or restoring-subtract (DIV) iteration per clock.
  - On the edge after the counter reaches WIDTH-1, the unit commits and returns to IDLE:
    - multu: {hi,lo} = a*b, full 2*WIDTH bits.
    - divu: lo = a/b, hi = a%b.
    - result = lo; zero = (lo==0); overflow = 0.
  - out_valid and in_ready both go to 1 in the cycle after commit, i.e. the WIDTH+1th cycle after the accept edge. A new op may be accepted that same cycle.
- divu with b==0: the full WIDTH iterations still run.
  - lo = all ones, hi = a, dbz = 1.
  - dbz = 0 on every other completion.
- Flags and result hold their value between out_valid pulses. Consumers sample only on out_valid.

Test Plan:
- add 0x7FFFFFFF + 0x00000001 -> next cycle out_valid=1, result=0x80000000, overflow=1, zero=0. Then sub 0x5 - 0x5 -> result=0, zero=1, overflow=0.
- slt a=0xFFFFFFFF, b=0x1 -> result=1. sltu with the same operands -> result=0. sra b=0x80000000, a=4 -> result=0xF8000000.
- multu 0xFFFFFFFF × 0xFFFFFFFF:
  - in_ready=0 for 32 cycles; in_valid pulses during busy are ignored.
  - out_valid exactly 33 cycles after the accept edge.
  - hi=0xFFFFFFFE, lo=0x00000001, result=0x00000001.
  - A following mfhi -> result=0xFFFFFFFE.
- divu 100 / 7 -> lo=14, hi=2, dbz=0. Then divu 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x1234, dbz=1, same 33-cycle latency.
- rst asserted 10 cycles into a multu -> next cycle in_ready=1, hi=lo=0, result=0, no out_valid pulse. A subsequent add 3+4 -> result=7.
- WIDTH=8 instance: multu 0xFF×0xFF -> hi=0xFE, lo=0x01 after 9 cycles. sll b=0x01, a=0x0F -> shift by a[2:0]=7, result=0x80.
